// File: rtl/buffer_shift_tap_mux.sv
// Index mux that picks one WIDTH-bit slot out of a packed NUM-slot window.
// Indices at or beyond NUM return zero, so callers never see undriven data.
module buffer_shift_tap_mux #(
  parameter int NUM   = 4,
  parameter int WIDTH = 16,
  parameter int IW    = $clog2(NUM + 1)
) (
  input  logic [WIDTH*NUM-1:0] data,
  input  logic [IW-1:0]        idx,
  output logic [WIDTH-1:0]     q
);

  always_comb begin
    q = '0;
    for (int i = 0; i < NUM; i++) begin
      if (idx == IW'(i)) begin
        q = data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/buffer_shift_window.sv
// Sliding-window shift buffer: words shift in at slot 0, the full NUM-word
// window is offered to a consumer, and each acknowledge retires STEP words.
module buffer_shift_window #(
  parameter  int NUM   = 4,
  parameter  int WIDTH = 16,
  parameter  int STEP  = 1,
  localparam int CW    = $clog2(NUM + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     din,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [WIDTH*NUM-1:0] dout,
  output logic [NUM-1:0]       vmask,
  output logic [CW-1:0]        count,
  input  logic [CW-1:0]        rd_idx,
  output logic [WIDTH-1:0]     rd_data
);

  if (NUM < 1 || STEP < 1 || STEP > NUM) begin : g_bad_params
    $error("buffer_shift_window: illegal NUM/STEP combination");
  end

  logic [WIDTH*NUM-1:0] buffer;
  logic [WIDTH*NUM-1:0] shifted;
  logic                 push;
  logic                 pop;

  if (NUM == 1) begin : g_single
    assign shifted = din;
  end else begin : g_chain
    assign shifted = {buffer[(NUM-1)*WIDTH-1:0], din};
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Both ready (in_ready) and valid (win_valid) are decoded only
  // from the registered count, so they are never both high and push/pop can
  // never coincide; a producer must hold din stable until in_ready is seen.
  assign in_ready  = (count != CW'(NUM));
  assign win_valid = (count == CW'(NUM));
  assign push      = in_valid & in_ready;
  assign pop       = win_valid & win_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer <= '0;
      count  <= '0;
    end else if (flush) begin
      buffer <= '0;
      count  <= '0;
    end else if (push) begin
      buffer <= shifted;
      count  <= count + CW'(1);
    end else if (pop) begin
      // Retired slots keep their data; later pushes shift it out.
      count <= CW'(NUM - STEP);
    end
  end

  always_comb begin
    vmask = '0;
    for (int i = 0; i < NUM; i++) begin
      vmask[i] = (CW'(i) < count);
    end
  end

  assign dout = buffer;

  buffer_shift_tap_mux #(
    .NUM   (NUM),
    .WIDTH (WIDTH),
    .IW    (CW)
  ) u_tap_mux (
    .data (buffer),
    .idx  (rd_idx),
    .q    (rd_data)
  );

endmodule
